// File: rtl/mac_dot_engine_pkg.sv
// Shared definitions for the MAC dot-product engine: default widths and
// the FSM state encoding used by the top level.
package mac_dot_engine_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 40;
  localparam int LEN_W  = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

endpackage

// File: rtl/mac_dot_engine_mac_pipe_stage.sv
// Registered signed multiplier followed by a wrapping accumulator.
// A product is captured on every fire cycle; its valid flag trails by one
// cycle and gates the accumulate. A clear input zeroes the running sum.
module mac_pipe_stage
  import mac_dot_engine_pkg::*;
#(
  parameter int DataWidth = DATA_W,
  parameter int AccWidth  = ACC_W
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 i_fire,
  input  logic                 i_acc_clr,
  input  logic [DataWidth-1:0] i_w_data,
  input  logic [DataWidth-1:0] i_i_data,
  output logic [AccWidth-1:0]  o_acc
);

  localparam int ProdWidth = 2 * DataWidth;

  logic signed [ProdWidth-1:0] w_w_sx;
  logic signed [ProdWidth-1:0] w_i_sx;
  logic signed [ProdWidth-1:0] w_prod;
  logic        [AccWidth-1:0]  r_prod;
  logic                        r_prod_v;
  logic        [AccWidth-1:0]  r_acc;

  // Operands are widened to the full product width first so the multiply
  // is evaluated as a signed full-width operation.
  assign w_w_sx = ProdWidth'($signed(i_w_data));
  assign w_i_sx = ProdWidth'($signed(i_i_data));
  assign w_prod = w_w_sx * w_i_sx;

  // Capture the sign-extended product on each pop; valid follows the pop.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_prod   <= '0;
      r_prod_v <= 1'b0;
    end else begin
      // NOTE: sequential state uses <= so every register samples pre-edge values.
      r_prod_v <= i_fire;
      if (i_fire) begin
        r_prod <= AccWidth'(w_prod);
      end
    end
  end

  // Accumulate valid products modulo 2^AccWidth; clear has priority.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_acc <= '0;
    end else if (i_acc_clr) begin
      r_acc <= '0;
    end else if (r_prod_v) begin
      r_acc <= r_acc + r_prod;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/mac_dot_engine.sv
// Dot-product engine: pops weight and activation FIFOs in lock-step,
// accumulates VecLen signed products and offers the sum on a valid/ready
// output. FSM, issue counter and handshake live here; arithmetic lives in
// mac_pipe_stage.
module mac_dot_engine
  import mac_dot_engine_pkg::*;
#(
  parameter int DataWidth = DATA_W,
  parameter int AccWidth  = ACC_W,  // must be at least 2*DataWidth
  parameter int LenWidth  = LEN_W
) (
  input  logic                 clk,
  input  logic                 aclr,
  input  logic                 Start,
  input  logic [LenWidth-1:0]  VecLen,
  input  logic                 W_Empty,
  input  logic                 I_Empty,
  input  logic [DataWidth-1:0] W_Data,
  input  logic [DataWidth-1:0] I_Data,
  output logic                 W_Pop,
  output logic                 I_Pop,
  output logic [AccWidth-1:0]  Acc_Out,
  output logic                 OutValid,
  input  logic                 OutReady,
  output logic                 Busy
);

  logic [1:0]          r_state;
  logic [LenWidth-1:0] r_len;
  logic [LenWidth-1:0] r_issued;
  logic [LenWidth-1:0] w_issued_nxt;
  logic                w_pop;
  logic                w_start;
  logic [AccWidth-1:0] w_acc;

  // FIFO DataOut is combinational, so the pop and the operand sample share
  // a cycle; both pops come from one term so they can never diverge.
  assign w_pop        = (r_state == ST_RUN) & ~W_Empty & ~I_Empty & (r_issued != r_len);
  assign w_start      = (r_state == ST_IDLE) & Start;
  assign w_issued_nxt = r_issued + LenWidth'(1);

  // Main control FSM with the issued-product counter.
  always_ff @(posedge clk or negedge aclr) begin
    if (!aclr) begin
      r_state  <= ST_IDLE;
      r_len    <= '0;
      r_issued <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_len    <= VecLen;
            r_issued <= '0;
            r_state  <= (VecLen != '0) ? ST_RUN : ST_OUT;
          end
        end
        ST_RUN: begin
          if (w_pop) begin
            r_issued <= w_issued_nxt;
            // Leave on the edge of the last pop so DRAIN covers its accumulate.
            if (w_issued_nxt == r_len) begin
              r_state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: r_state <= ST_OUT;
        ST_OUT: begin
          if (OutReady) begin
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  mac_pipe_stage #(
    .DataWidth (DataWidth),
    .AccWidth  (AccWidth)
  ) u_pipe (
    .clk       (clk),
    .aclr      (aclr),
    .i_fire    (w_pop),
    .i_acc_clr (w_start),
    .i_w_data  (W_Data),
    .i_i_data  (I_Data),
    .o_acc     (w_acc)
  );

  assign W_Pop    = w_pop;
  assign I_Pop    = w_pop;
  assign Acc_Out  = w_acc;
  assign OutValid = (r_state == ST_OUT);
  assign Busy     = (r_state != ST_IDLE);

endmodule

// File: doc/mac_dot_engine.md
Name: mac_dot_engine

Overview:
- Downstream consumer of two dual-read FIFO buffers: one holds weights, one holds input activations.
- Pops one word from each FIFO in lock-step and forms a signed product. Accumulates VecLen products into a dot product.
- Presents the result on a valid/ready output handshake.
- Uses read port 1 (Pop1/DataOut1/Empty) of each FIFO. The FIFO's DataOut is combinational from its read pointer, so data is sampled in the same cycle the pop is asserted.

Parameters:
- DataWidth, 16, signed two's-complement operand width; matches FIFO DataWidth.
- AccWidth, 40, accumulator and result width; must be ≥ 2*DataWidth.
- LenWidth, 8, width of the vector-length field.

Ports:
- clk  input  1  clock, rising edge.
- aclr  input  1  asynchronous reset, active-low.
- Start  input  1  begin a dot product; sampled only in IDLE.
- VecLen  input  LenWidth  number of products; captured on accepted Start.
- W_Empty  input  1  weight FIFO Empty.
- I_Empty  input  1  input FIFO Empty.
- W_Data  input  DataWidth  weight FIFO DataOut1.
- I_Data  input  DataWidth  input FIFO DataOut1.
- W_Pop  output  1  weight FIFO Pop1.
- I_Pop  output  1  input FIFO Pop1.
- Acc_Out  output  AccWidth  dot-product result.
- OutValid  output  1  Acc_Out valid.
- OutReady  input  1  downstream accepts result.
- Busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (aclr low, asynchronous):
  - State returns to IDLE.
  - Counters, accumulator, product register and product-valid flag clear to 0.
  - Acc_Out=0, OutValid=0, Busy=0, W_Pop=I_Pop=0.
  - Reset mid-operation abandons the partial sum. FIFO words already popped are lost; no recovery.
- States: IDLE, RUN, DRAIN, OUT.
- IDLE:
  - Start=1 captures VecLen into len_r and clears issued counter and accumulator.
  - Goes to RUN if VecLen≠0, else to OUT with Acc_Out=0.
  - Start in any other state is ignored.
- RUN:
  - W_Pop = I_Pop = ~W_Empty & ~I_Empty & (issued≠len_r). This is combinational.
  - The two pops are always equal: never pop one FIFO without the other.
  - On a pop cycle:
    - prod_r <= signed(W_Data)*signed(I_Data), sign-extended to AccWidth.
    - prod_v <= 1 and issued <= issued+1.
  - Otherwise prod_v <= 0.
  - Either FIFO empty stalls issue. prod_v drops, the accumulator holds, and no bubble state is needed.
  - When issued reaches len_r, go to DRAIN.
- Accumulate stage (all states): if prod_v, acc <= acc + prod_r, wrapping modulo 2^AccWidth with no saturation.
- DRAIN: wait one cycle for the final prod_v to accumulate, then go to OUT.
- OUT:
  - OutValid=1 and Acc_Out=acc, held stable while OutReady=0.
  - OutValid&OutReady returns to IDLE; OutValid falls next cycle.
  - Start in the same cycle is ignored.
- Latency: with N back-to-back pops in cycles t..t+N-1, the last accumulation happens at the end of cycle t+N. OutValid is high from cycle t+N+1.
- Throughput: one product per cycle when both FIFOs are non-empty.
- Simultaneous events:
  - A FIFO going empty in the same cycle as the final pop is irrelevant.
  - An empty-to-non-empty transition is seen the same cycle (combinational Empty).

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DRAIN=2'd2, OUT=2'd3;
  - default widths DATA_W=16, ACC_W=40, LEN_W=8.
- One natural sub-module: mac_pipe_stage. It contains the registered signed multiplier (prod_r/prod_v) and the accumulator with a clear input. The FSM, counter and handshake stay in the top.

Test Plan:
- Basic: VecLen=4, both FIFOs preloaded with W={1,2,3,4}, I={5,6,7,8}, Start pulse → four consecutive pops, OutValid at cycle t+5, Acc_Out=70.
- Signed/stall: VecLen=3, W={-3,100,-32768}, I={7,-2,-32768}. Hold I_Empty=1 for 2 cycles mid-stream → no pops while empty; W_Pop==I_Pop every cycle; Acc_Out=-21-200+1073741824=1073741603.
- Backpressure: result ready, OutReady=0 for 5 cycles → OutValid and Acc_Out stable. Start pulses during this window are ignored. The handshake completes on OutReady=1, and OutValid is low the next cycle.
- Zero length: VecLen=0 with Start → no pops; OutValid next cycle with Acc_Out=0.
- Reset mid-RUN: VecLen=8, assert aclr low after 3 pops → all outputs 0 immediately (asynchronous). After release, a new Start with VecLen=2, W={2,2}, I={3,3} → Acc_Out=12, with no carry-over from the aborted run.
- Wrap: AccWidth=32 override, VecLen=3, W=I={-32768} each → Acc_Out = 3*2^30 mod 2^32, read as signed = -1073741824.
